// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC constants (Q3.29 angles, gain inverse, state encoding).
package cordic_pkg;
   localparam int W     = 32;
   localparam int FRAC  = 29;
   localparam int GUARD = 2;
   localparam logic signed [W-1:0] PI_HALF = 32'sh3243_F6A8;
   localparam logic signed [W-1:0] PI      = 32'sh6487_ED51;
   localparam logic signed [W-1:0] K_INV   = 32'sd326016437;
   // atan(2^-i) in Q3.29, rounded to nearest
   localparam logic signed [W-1:0] ATAN_TABLE [32] = '{
      32'sd421657428, 32'sd248918915, 32'sd131521918, 32'sd66762579,
      32'sd33510843,  32'sd16771758,  32'sd8387925,   32'sd4194219,
      32'sd2097141,   32'sd1048575,   32'sd524288,    32'sd262144,
      32'sd131072,    32'sd65536,     32'sd32768,     32'sd16384,
      32'sd8192,      32'sd4096,      32'sd2048,      32'sd1024,
      32'sd512,       32'sd256,       32'sd128,       32'sd64,
      32'sd32,        32'sd16,        32'sd8,         32'sd4,
      32'sd2,         32'sd1,         32'sd0,         32'sd0
   };
   typedef enum logic [2:0] {IDLE, PRE, ITER, COMP, DONE} state_t;
endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: combinational atan(2^-i) lookup shared by the CORDIC engines.
module cordic_atan_rom
   import cordic_pkg::*;
(
   input  logic [4:0]          idx,
   output logic signed [W-1:0] angle
);
   assign angle = ATAN_TABLE[idx];
endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring CORDIC, (X, Y) -> (magnitude, atan2(Y, X)) in Q3.29.
// Define CORDIC_GAIN_COMP_EN to add a final 1/K multiply so X_n is the true magnitude.
module cordic_vectoring
   import cordic_pkg::*;
#(
   parameter int ITERATIONS = 28,
   parameter int IW         = W + GUARD
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic signed [W-1:0] X_zero,
   input  logic signed [W-1:0] Y_zero,
   output logic                busy,
   output logic                done,
   output logic [W-1:0]        X_n,
   output logic [W-1:0]        Y_n,
   output logic [W-1:0]        Z_n
);
   state_t state, next;
   logic signed [IW-1:0] x, y, z, xs, ys;
   logic signed [W-1:0]  atan;
   logic [4:0]           i;
   logic                 zero, last;
   cordic_atan_rom rom (.idx(i), .angle(atan));
   assign xs   = x >>> i;
   assign ys   = y >>> i;
   assign last = i == 5'(ITERATIONS - 1);
   assign busy = state != IDLE;
`ifdef CORDIC_GAIN_COMP_EN
   logic signed [IW+W-1:0] prod;
   assign prod = x * K_INV;
`endif
   function automatic logic [W-1:0] sat(input logic signed [IW-1:0] v);
      return (&v[IW-1:W-1] || !(|v[IW-1:W-1])) ? v[W-1:0] : (v[IW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);
   endfunction
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      case (state)
         IDLE: next = start ? PRE : IDLE;
         PRE:  next = ITER;
`ifdef CORDIC_GAIN_COMP_EN
         ITER: next = last ? COMP : ITER;
         COMP: next = DONE;
`else
         ITER: next = last ? DONE : ITER;
`endif
         DONE: next = IDLE;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         {x, y, z} <= '0;
         i <= '0;
         zero <= 1'b0;
         done <= 1'b0;
         {X_n, Y_n, Z_n} <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               x <= IW'(X_zero);
               y <= IW'(Y_zero);
               zero <= X_zero == '0 && Y_zero == '0;
            end
            PRE: begin
               i <= '0;
               // fold left half-plane into the right so the iteration range covers it
               if (!x[IW-1]) z <= '0;
               else if (!y[IW-1]) begin
                  x <= y;
                  y <= -x;
                  z <= IW'(PI_HALF);
               end else begin
                  x <= -y;
                  y <= x;
                  z <= -IW'(PI_HALF);
               end
            end
            ITER: begin
               x <= y[IW-1] ? x - ys : x + ys;
               y <= y[IW-1] ? y + xs : y - xs;
               z <= y[IW-1] ? z - IW'(atan) : z + IW'(atan);
               i <= i + 1'b1;
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: x <= IW'(prod >>> FRAC);
`endif
            DONE: begin
               X_n <= sat(x);
               Y_n <= sat(y);
               Z_n <= zero ? '0 : sat(z);
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: directed vectors with hand-computed polar results, ±64 LSB tolerance.
module tb_cordic_vectoring;
   localparam int ITER = 28;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int          LAT  = ITER + 3;
   localparam logic [31:0] MAG1 = 32'h2000_0000;
   localparam logic [31:0] MAG2 = 32'h2D41_3CCD;
`else
   localparam int          LAT  = ITER + 2;
   localparam logic [31:0] MAG1 = 32'd884097682;
   localparam logic [31:0] MAG2 = 32'd1250302932;
`endif
   localparam logic [31:0] ONE   = 32'h2000_0000;
   localparam logic [31:0] M_ONE = 32'hE000_0000;
   localparam logic [31:0] Q_PI  = 32'h1921_FB54;
   localparam logic [31:0] H_PI  = 32'h3243_F6A8;
   localparam logic [31:0] F_PI  = 32'h6487_ED51;
   localparam logic [31:0] NH_PI = 32'hCDBC_0958;

   logic clk = 0, rst = 1, start = 0;
   logic signed [31:0] X_zero = 0, Y_zero = 0;
   logic busy, done;
   logic [31:0] X_n, Y_n, Z_n;
   int checks = 0, errors = 0, cyc = 0, nd = 0;

   always #5 clk = ~clk;

   cordic_vectoring #(.ITERATIONS(ITER)) dut (
      .clk(clk), .rst(rst), .start(start), .X_zero(X_zero), .Y_zero(Y_zero),
      .busy(busy), .done(done), .X_n(X_n), .Y_n(Y_n), .Z_n(Z_n)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic near(input string tag, input logic [31:0] got, input logic [31:0] exp);
      longint d;
      logic ok;
      d = longint'($signed(got)) - longint'($signed(exp));
      ok = (d >= -64 && d <= 64);
      checks++;
      assert (ok === 1'b1) else begin
         errors++;
         $error("FAIL %s: got %h expected %h +-64", tag, got, exp);
      end
   endtask

   task automatic go(input logic [31:0] x, input logic [31:0] y);
      X_zero = x;
      Y_zero = y;
      start = 1;
      tick;
      start = 0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 200) begin
         tick;
         cyc++;
      end
   endtask

   initial begin
      repeat (3) tick;
      eq("rst_busy", 32'(busy), 0);
      eq("rst_done", 32'(done), 0);
      eq("rst_x", X_n, 0);
      eq("rst_y", Y_n, 0);
      eq("rst_z", Z_n, 0);
      rst = 0;
      tick;

      go(ONE, 0);
      eq("lat_1_0", cyc, LAT);
      near("x_1_0", X_n, MAG1);
      near("y_1_0", Y_n, 0);
      near("z_1_0", Z_n, 0);
      tick;
      eq("done_pulse", 32'(done), 0);

      go(ONE, ONE);
      near("x_1_1", X_n, MAG2);
      near("z_1_1", Z_n, Q_PI);

      go(M_ONE, 0);
      near("x_m1_0", X_n, MAG1);
      near("z_m1_0", Z_n, F_PI);

      go(0, M_ONE);
      near("z_0_m1", Z_n, NH_PI);

      go(0, 0);
      eq("x_0_0", X_n, 0);
      eq("y_0_0", Y_n, 0);
      eq("z_0_0", Z_n, 0);

      go(32'h7FFF_FFFF, 32'h7FFF_FFFF);
      eq("x_max", X_n, 32'h7FFF_FFFF);
      near("z_max", Z_n, Q_PI);

      X_zero = 0;
      Y_zero = ONE;
      start = 1;
      tick;
      start = 0;
      eq("busy_run", 32'(busy), 1);
      nd = 0;
      for (int k = 1; k < LAT + 10; k++) begin
         if (k == 5) begin
            X_zero = M_ONE;
            Y_zero = 0;
            start = 1;
         end else start = 0;
         tick;
         if (done) nd++;
      end
      eq("ignore_ndone", nd, 1);
      near("ignore_z", Z_n, H_PI);
      near("ignore_x", X_n, MAG1);

      X_zero = ONE;
      Y_zero = 0;
      start = 1;
      tick;
      start = 0;
      repeat (11) tick;
      rst = 1;
      tick;
      rst = 0;
      eq("abort_busy", 32'(busy), 0);
      eq("abort_done", 32'(done), 0);
      eq("abort_x", X_n, 0);
      eq("abort_y", Y_n, 0);
      eq("abort_z", Z_n, 0);
      nd = 0;
      repeat (LAT + 5) begin
         tick;
         if (done) nd++;
      end
      eq("abort_ndone", nd, 0);
      go(ONE, ONE);
      eq("lat_after", cyc, LAT);
      near("z_after", Z_n, Q_PI);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

- Iterative CORDIC in vectoring mode: the inverse direction of the rotation-mode `Cordic_Machine`.
- Takes a Cartesian vector (X, Y) in Q3.29 and returns its magnitude and its angle atan2(Y, X) in radians, Q3.29.
- Sits beside `Cordic_Machine` in the CORDIC datapath so that rotation results can be converted back to polar form.
- Adds a start/busy/done handshake in place of free-running operation.

## Interface
Parameters:
- `ITERATIONS`, 28: micro-rotations performed; legal range 1..30.
- `IW`, 34: internal datapath width, i.e. 32 bits plus 2 guard bits (Q5.29).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `X_zero` in 32: signed X, Q3.29.
- `Y_zero` in 32: signed Y, Q3.29.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse; results are valid from this cycle onward.
- `X_n` out 32: magnitude, Q3.29, unsigned value in signed container, saturated.
- `Y_n` out 32: residual Y after the last iteration, Q3.29, saturated; ideally about 0.
- `Z_n` out 32: angle in (-pi, +pi], Q3.29.

## Operation
- States: IDLE → PRE → ITER → (COMP) → DONE → IDLE.
- IDLE:
  - If `start` is high, latch `X_zero`/`Y_zero` sign-extended to `IW` and go to PRE.
  - With `start` low, stay in IDLE.
- PRE (quadrant pre-rotation):
  - If x ≥ 0: no change, z = 0.
  - If x < 0 and y ≥ 0: (x, y) ← (y, −x), z = +pi/2.
  - If x < 0 and y < 0: (x, y) ← (−y, x), z = −pi/2.
  - Clear iteration counter i.
- ITER: one micro-rotation per cycle.
  - If y ≥ 0: x += y>>>i; y −= x>>>i; z += atan(2^−i).
  - Otherwise apply the opposite signs.
  - Shifts are arithmetic and use the pre-update values.
  - After i = `ITERATIONS`−1, go to COMP if compiled in, else DONE.
- COMP: x ← (x × K_INV) >>> 29. Full-precision product, truncated toward −inf.
- DONE:
  - Register outputs, saturating to the 32-bit signed range (0x7FFFFFFF / 0x80000000).
  - Pulse `done`, return to IDLE.
- Outputs hold their last values until the next DONE.
- `start` while busy is ignored: no queueing and no restart.
- (0, 0) input: X_n = 0, Y_n = 0, Z_n = 0.
- (−a, 0) input: Z_n ≈ +pi (0x6487ED51), never −pi.
- The magnitude is scaled by the CORDIC gain K ≈ 1.64676 unless compensation is compiled in.

## Timing
- Reset values: `busy` = 0, `done` = 0, `X_n` = `Y_n` = `Z_n` = 0, state = IDLE.
- `rst` asserted mid-operation aborts the calculation on that edge. There is no `done` and the outputs are cleared.
- Let edge 0 be the edge that samples `start`:
  - PRE executes at edge 1.
  - Iterations execute at edges 2..`ITERATIONS`+1.
  - `done` is high in the cycle after edge `ITERATIONS`+2, or `ITERATIONS`+3 with COMP.
- Default latency: `start` to `done` is 30 cycles (31 with COMP).
- Next `start` is accepted in the cycle after `done` (IDLE). Back-to-back throughput is `ITERATIONS`+3 (+1) cycles.

## Configuration
- `CORDIC_GAIN_COMP_EN` defined:
  - COMP state present; `X_n` = true magnitude.
  - Latency +1 cycle.
- `CORDIC_GAIN_COMP_EN` undefined:
  - No COMP state and no multiplier.
  - `X_n` = K × magnitude.

## Structure
- Package `cordic_pkg`, holding:
  - `ATAN_TABLE[0..31]`: atan(2^−i) in Q3.29, rounded to nearest.
  - `PI_HALF` = 0x3243F6A8.
  - `PI` = 0x6487ED51.
  - `K_INV` = round(0.6072529350 × 2^29).
  - State enum typedef.
  - Q-format width constants.
- Sub-module `cordic_atan_rom`: combinational lookup of `ATAN_TABLE` indexed by i, shared with `Cordic_Machine`.

## Test plan
Tolerances are ±64 LSB on all values.
- (0x20000000, 0), i.e. (1.0, 0) → Z_n ≈ 0, Y_n ≈ 0.
  - Without comp: X_n ≈ 0x34B2_xxxx (1.64676).
  - With comp: X_n ≈ 0x20000000.
  - `done` exactly at the latency stated in Timing.
- (1.0, 1.0) → Z_n ≈ 0x1921FB54 (pi/4); with comp, X_n ≈ 0x2D413CCD (sqrt 2).
- (−1.0, 0) → Z_n ≈ 0x6487ED51 (+pi). (0, −1.0) → Z_n ≈ 0xCDBC0958 (−pi/2). (0, 0) → all outputs 0.
- Max-range input (0x7FFFFFFF, 0x7FFFFFFF) without comp → X_n saturates to 0x7FFFFFFF, and Z_n ≈ pi/4.
- `start` pulsed again mid-run → ignored; one `done`, and results belong to the first input.
- `rst` asserted at iteration 10 → next cycle `busy` = 0 and outputs are 0, with no `done`. A new `start` then completes normally.
